// File: rtl/melody_pkg.sv
// rtl/melody_pkg.sv - note codes, FSM encoding, ROM entry layout and song table for melody_sequencer
package melody_pkg;

  localparam logic [1:0] NOTE_C4  = 2'b00;
  localparam logic [1:0] NOTE_E4  = 2'b01;
  localparam logic [1:0] NOTE_AB4 = 2'b10;
  localparam logic [1:0] NOTE_C5  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_PLAY,
    ST_GAP,
    ST_DONE
  } seq_state_e;

  // Entry layout: {rest, note[1:0], dur[ROM_DUR_W-1:0]}
  localparam int ROM_DUR_W = 10;
  localparam int NOTE_OFS  = ROM_DUR_W;
  localparam int REST_OFS  = ROM_DUR_W + 2;
  localparam int ENTRY_W   = ROM_DUR_W + 3;

  function automatic logic [ENTRY_W-1:0] mk_entry(input logic rest, input logic [1:0] note,
                                                  input int unsigned dur);
    return {rest, note, ROM_DUR_W'(dur)};
  endfunction

  // dur == 0 terminates the song; unlisted indices read as the terminator
  function automatic logic [ENTRY_W-1:0] song_entry(input int idx);
    case (idx)
      0:       return mk_entry(1'b0, NOTE_C4, 3);
      1:       return mk_entry(1'b0, NOTE_E4, 2);
      2:       return mk_entry(1'b1, NOTE_C5, 2);
      3:       return mk_entry(1'b0, NOTE_AB4, 1);
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - duration tick prescaler with synchronous clear
module tick_gen #(
  parameter int unsigned CYCLES = 50000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(CYCLES - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + W'(1);
    if (clr_i || tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/melody_sequencer.sv
// rtl/melody_sequencer.sv - song ROM player driving note select and tone gate; MELODY_TEMPO_EN adds tempo scaling
module melody_sequencer
  import melody_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 50000000,
  parameter int unsigned TICK_HZ   = 1000,
  parameter int unsigned SONG_LEN  = 16,
  parameter int unsigned DUR_W     = 10,
  parameter int unsigned GAP_TICKS = 20
) (
  input  logic                        clk_50MHz,
  input  logic                        reset_button,
  input  logic                        start,
  input  logic                        stop,
  input  logic                        loop,
`ifdef MELODY_TEMPO_EN
  input  logic [1:0]                  tempo,
`endif
  output logic [1:0]                  state,
  output logic                        tone_en,
  output logic                        busy,
  output logic [$clog2(SONG_LEN)-1:0] step_idx,
  output logic                        done
);

  localparam int unsigned TICK_CYCLES = CLK_HZ / TICK_HZ;
  localparam int IDX_W = $clog2(SONG_LEN);
  localparam int IW1   = IDX_W + 1;
  localparam int CNT_W = DUR_W + 3;
  localparam int GAP_W = 16;
  localparam logic [IW1-1:0] END_IDX = IW1'(SONG_LEN);

  seq_state_e     fsm_q, fsm_d;
  logic [IW1-1:0] idx_q, idx_d;
  logic [1:0]     note_q, note_d;
  logic           rest_q, rest_d;
  logic [CNT_W-1:0] dur_q, dur_d;
  logic [GAP_W-1:0] gap_q, gap_d;

  logic               tick, tick_clr;
  logic [ENTRY_W-1:0] rom_entry;
  logic [DUR_W-1:0]   rom_dur;
  logic [1:0]         tempo_sh;

`ifdef MELODY_TEMPO_EN
  assign tempo_sh = tempo;
`else
  assign tempo_sh = 2'd0;
`endif

  assign rom_entry = song_entry(int'(idx_q));
  assign rom_dur   = DUR_W'(rom_entry[ROM_DUR_W-1:0]);
  assign tick_clr  = (fsm_q == ST_LOAD);

  tick_gen #(.CYCLES(TICK_CYCLES)) u_tick (
    .clk_i (clk_50MHz),
    .rst_i (reset_button),
    .clr_i (tick_clr),
    .tick_o(tick)
  );

  always_comb begin
    fsm_d  = fsm_q;
    idx_d  = idx_q;
    note_d = note_q;
    rest_d = rest_q;
    dur_d  = dur_q;
    gap_d  = gap_q;
    case (fsm_q)
      ST_IDLE: if (start) begin
        fsm_d = ST_LOAD;
        idx_d = '0;
      end
      ST_LOAD: begin
        if (idx_q == END_IDX || rom_dur == '0) begin
          fsm_d = ST_DONE;
        end else begin
          note_d = rom_entry[NOTE_OFS +: 2];
          rest_d = rom_entry[REST_OFS];
          dur_d  = CNT_W'(rom_dur) << tempo_sh;
          fsm_d  = ST_PLAY;
        end
      end
      ST_PLAY: if (tick) begin
        if (dur_q == CNT_W'(1)) begin
          if (GAP_TICKS > 0) begin
            fsm_d = ST_GAP;
            gap_d = GAP_W'(GAP_TICKS);
          end else begin
            fsm_d = ST_LOAD;
            idx_d = idx_q + IW1'(1);
          end
        end else begin
          dur_d = dur_q - CNT_W'(1);
        end
      end
      ST_GAP: if (tick) begin
        if (gap_q == GAP_W'(1)) begin
          fsm_d = ST_LOAD;
          idx_d = idx_q + IW1'(1);
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      ST_DONE: begin
        idx_d = '0;
        fsm_d = loop ? ST_LOAD : ST_IDLE;
      end
      default: fsm_d = ST_IDLE;
    endcase
    // stop dominates start and every in-flight transition; note select is left untouched
    if (stop) begin
      fsm_d = ST_IDLE;
      idx_d = '0;
    end
  end

  always_ff @(posedge clk_50MHz) begin
    if (reset_button) begin
      fsm_q  <= ST_IDLE;
      idx_q  <= '0;
      note_q <= NOTE_C4;
      rest_q <= 1'b0;
      dur_q  <= '0;
      gap_q  <= '0;
    end else begin
      fsm_q  <= fsm_d;
      idx_q  <= idx_d;
      note_q <= note_d;
      rest_q <= rest_d;
      dur_q  <= dur_d;
      gap_q  <= gap_d;
    end
  end

  assign state    = note_q;
  assign tone_en  = (fsm_q == ST_PLAY) && !rest_q;
  assign busy     = (fsm_q != ST_IDLE);
  assign done     = (fsm_q == ST_DONE);
  // The one-past-end index only lives for the final LOAD/DONE; show the last entry instead
  assign step_idx = (idx_q == END_IDX) ? IDX_W'(SONG_LEN - 1) : idx_q[IDX_W-1:0];

endmodule

// File: tb/tb_melody_sequencer.sv
// tb/tb_melody_sequencer.sv - scoreboard bench: run-length output segments checked against hand-computed expectations
module tb_melody_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic stop = 1'b0;
  logic loop = 1'b0;
`ifdef MELODY_TEMPO_EN
  logic [1:0] tempo = 2'd0;
`endif
  logic [1:0] state;
  logic       tone_en, busy, done;
  logic [3:0] step_idx;

  always #5 clk = ~clk;

  melody_sequencer #(
    .CLK_HZ(1000), .TICK_HZ(100), .SONG_LEN(16), .DUR_W(10), .GAP_TICKS(1)
  ) dut (
    .clk_50MHz   (clk),
    .reset_button(rst),
    .start       (start),
    .stop        (stop),
    .loop        (loop),
`ifdef MELODY_TEMPO_EN
    .tempo       (tempo),
`endif
    .state       (state),
    .tone_en     (tone_en),
    .busy        (busy),
    .step_idx    (step_idx),
    .done        (done)
  );

  typedef struct {
    bit         idle;
    logic [7:0] t;
    int         len;
  } seg_t;

  seg_t exp_q[$];
  int errors = 0;
  int checks = 0;
  int seg_no = 0;

  function automatic logic [7:0] tup(input logic [1:0] s, input logic te, input logic dn,
                                     input logic [3:0] ix);
    return {s, te, dn, ix};
  endfunction

  task automatic exp_seg(input logic [1:0] s, input logic te, input logic dn,
                         input logic [3:0] ix, input int len);
    seg_t e;
    e.idle = 1'b0;
    e.t    = tup(s, te, dn, ix);
    e.len  = len;
    exp_q.push_back(e);
  endtask

  task automatic exp_idle(input logic [1:0] s);
    seg_t e;
    e.idle = 1'b1;
    e.t    = tup(s, 1'b0, 1'b0, 4'd0);
    e.len  = 0;
    exp_q.push_back(e);
  endtask

  // Whole song from LOAD(step 0) to the DONE cycle; m is the tempo multiplier, gap is 10 cycles unscaled
  task automatic push_song(input logic [1:0] prev, input int m);
    exp_seg(prev,  1'b0, 1'b0, 4'd0, 1);
    exp_seg(2'd0,  1'b1, 1'b0, 4'd0, 30 * m);
    exp_seg(2'd0,  1'b0, 1'b0, 4'd0, 10);
    exp_seg(2'd0,  1'b0, 1'b0, 4'd1, 1);
    exp_seg(2'd1,  1'b1, 1'b0, 4'd1, 20 * m);
    exp_seg(2'd1,  1'b0, 1'b0, 4'd1, 10);
    exp_seg(2'd1,  1'b0, 1'b0, 4'd2, 1);
    exp_seg(2'd3,  1'b0, 1'b0, 4'd2, 20 * m + 10);
    exp_seg(2'd3,  1'b0, 1'b0, 4'd3, 1);
    exp_seg(2'd2,  1'b1, 1'b0, 4'd3, 10 * m);
    exp_seg(2'd2,  1'b0, 1'b0, 4'd3, 10);
    exp_seg(2'd2,  1'b0, 1'b0, 4'd4, 1);
    exp_seg(2'd2,  1'b0, 1'b1, 4'd4, 1);
  endtask

  task automatic check_seg(input bit idle, input logic [7:0] t, input int len);
    seg_t e;
    checks++;
    seg_no++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL seg%0d unexpected: got idle=%0b tup=%h len=%0d, required no segment",
               seg_no, idle, t, len);
    end else begin
      e = exp_q.pop_front();
      if (e.idle != idle || e.t !== t || e.len != len) begin
        errors++;
        $display("FAIL seg%0d: got idle=%0b tup=%h len=%0d, required idle=%0b tup=%h len=%0d",
                 seg_no, idle, t, len, e.idle, e.t, e.len);
      end
    end
  endtask

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, got, want);
    end
  endtask

  // Monitor: run-length encode {state,tone_en,done,step_idx} while busy; emit an idle marker when busy drops
  logic [7:0] cur_t;
  int         cur_len = 0;
  bit         in_busy = 1'b0;
  always @(negedge clk) begin
    logic [7:0] t;
    t = tup(state, tone_en, done, step_idx);
    if (busy === 1'b1) begin
      if (!in_busy || t !== cur_t) begin
        if (in_busy) check_seg(1'b0, cur_t, cur_len);
        cur_t   = t;
        cur_len = 1;
        in_busy = 1'b1;
      end else begin
        cur_len++;
      end
    end else if (in_busy) begin
      check_seg(1'b0, cur_t, cur_len);
      check_seg(1'b1, t, 0);
      in_busy = 1'b0;
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    @(negedge clk);
    while (busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL wait_idle timeout: busy=%b after %0d cycles, required 0", busy, budget);
    end
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    @(negedge clk);
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL wait_done timeout: done=%b after %0d cycles, required 1", done, budget);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_state", int'(state), 0);
    chk("rst_tone_en", int'(tone_en), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_step_idx", int'(step_idx), 0);

    // Full song; a start re-pulse during the second note must change nothing
    push_song(2'd0, 1);
    exp_idle(2'd2);
    pulse_start();
    repeat (50) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_idle(400);
    repeat (3) @(posedge clk);

    // stop sampled in the 5th cycle of the second note
    exp_seg(2'd2, 1'b0, 1'b0, 4'd0, 1);
    exp_seg(2'd0, 1'b1, 1'b0, 4'd0, 30);
    exp_seg(2'd0, 1'b0, 1'b0, 4'd0, 10);
    exp_seg(2'd0, 1'b0, 1'b0, 4'd1, 1);
    exp_seg(2'd1, 1'b1, 1'b0, 4'd1, 5);
    exp_idle(2'd1);
    pulse_start();
    repeat (46) @(posedge clk);
    #1 stop = 1'b1;
    @(posedge clk); #1 stop = 1'b0;
    wait_idle(50);
    repeat (3) @(posedge clk);

    // reset at the same point: note select returns to 00
    exp_seg(2'd1, 1'b0, 1'b0, 4'd0, 1);
    exp_seg(2'd0, 1'b1, 1'b0, 4'd0, 30);
    exp_seg(2'd0, 1'b0, 1'b0, 4'd0, 10);
    exp_seg(2'd0, 1'b0, 1'b0, 4'd1, 1);
    exp_seg(2'd1, 1'b1, 1'b0, 4'd1, 5);
    exp_idle(2'd0);
    pulse_start();
    repeat (46) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    wait_idle(50);
    repeat (3) @(posedge clk);

    // start and stop together from IDLE: no segment expected
    @(posedge clk); #1 start = 1'b1; stop = 1'b1;
    @(posedge clk); #1 start = 1'b0; stop = 1'b0;
    @(negedge clk);
    chk("start_stop_busy", int'(busy), 0);
    repeat (3) @(posedge clk);

    // loop: second pass follows DONE directly through LOAD at step 0
    push_song(2'd0, 1);
    push_song(2'd2, 1);
    exp_idle(2'd2);
    loop = 1'b1;
    pulse_start();
    wait_done(400);
    @(posedge clk); #1 loop = 1'b0;
    wait_idle(400);
    repeat (3) @(posedge clk);

`ifdef MELODY_TEMPO_EN
    tempo = 2'b01;
    push_song(2'd2, 2);
    exp_idle(2'd2);
    pulse_start();
    wait_idle(800);
    tempo = 2'b00;
    repeat (3) @(posedge clk);
`endif

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending segments, required 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
